// File: rtl/mem_load_unit_if.sv
// Load-unit request, memory and result bundle.
// master = requester/memory side, slave = load unit.
interface mem_load_unit_if;
    logic        req_valid;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [4:0]  req_rd;
    logic        req_ready;
    logic        mem_re;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        ld_err;
    logic        stall;

    modport master (
        output req_valid, req_op, req_addr, req_rd, mem_rdata,
        input  req_ready, mem_re, mem_addr, ld_valid,
        input  ld_data, ld_rd, ld_err, stall
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_rd, mem_rdata,
        output req_ready, mem_re, mem_addr, ld_valid,
        output ld_data, ld_rd, ld_err, stall
    );
endinterface

// File: rtl/mem_load_unit.sv
// Three-cycle load unit: issue word read, capture, format lb/lh/lw/lbu/lhu.
// Bad requests complete next cycle with ld_err and no memory access.
module mem_load_unit (
    input  logic           clk,
    input  logic           rst,
    mem_load_unit_if.slave bus
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    typedef enum logic [1:0] {IDLE, READ, CAPT} state_t;

    state_t      state;
    logic [5:0]  op_q;
    logic [9:0]  addr_q;
    logic [4:0]  rd_q;
    logic        mem_re;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        ld_err;
    logic        req_err;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] fmt;
    logic        unused_addr;

    assign unused_addr   = ^bus.req_addr[31:10];
    assign bus.req_ready = (state == IDLE);
    assign bus.stall     = (state != IDLE);
    assign bus.mem_re    = mem_re;
    // addr_q only moves on a real read, so mem_addr holds between reads
    assign bus.mem_addr  = addr_q[9:2];
    assign bus.ld_valid  = ld_valid;
    assign bus.ld_data   = ld_data;
    assign bus.ld_rd     = ld_rd;
    assign bus.ld_err    = ld_err;

    always_comb begin
        req_err = 1'b1;
        case (bus.req_op)
            OP_LB, OP_LBU: req_err = 1'b0;
            OP_LH, OP_LHU: req_err = bus.req_addr[0];
            OP_LW:         req_err = |bus.req_addr[1:0];
            default:       req_err = 1'b1;
        endcase
    end

    always_comb begin
        sel_byte = bus.mem_rdata[7:0];
        unique case (addr_q[1:0])
            2'd0: sel_byte = bus.mem_rdata[7:0];
            2'd1: sel_byte = bus.mem_rdata[15:8];
            2'd2: sel_byte = bus.mem_rdata[23:16];
            2'd3: sel_byte = bus.mem_rdata[31:24];
        endcase
        sel_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        fmt = bus.mem_rdata;
        case (op_q)
            OP_LB:   fmt = {{24{sel_byte[7]}}, sel_byte};
            OP_LH:   fmt = {{16{sel_half[15]}}, sel_half};
            OP_LBU:  fmt = {24'b0, sel_byte};
            OP_LHU:  fmt = {16'b0, sel_half};
            default: fmt = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            rd_q     <= '0;
            mem_re   <= 1'b0;
            ld_valid <= 1'b0;
            ld_data  <= '0;
            ld_rd    <= '0;
            ld_err   <= 1'b0;
        end else begin
            ld_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (req_err) begin
                            ld_valid <= 1'b1;
                            ld_err   <= 1'b1;
                            ld_data  <= '0;
                            ld_rd    <= bus.req_rd;
                        end else begin
                            op_q   <= bus.req_op;
                            addr_q <= bus.req_addr[9:0];
                            rd_q   <= bus.req_rd;
                            mem_re <= 1'b1;
                            state  <= READ;
                        end
                    end
                end
                READ: begin
                    mem_re <= 1'b0;
                    state  <= CAPT;
                end
                CAPT: begin
                    ld_valid <= 1'b1;
                    ld_err   <= 1'b0;
                    ld_data  <= fmt;
                    ld_rd    <= rd_q;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_load_unit.sv
// Randomized bench for mem_load_unit against a queue-based load model.
// Directed table pins the model and DUT to hand-computed results.
module tb_mem_load_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_load_unit_if bus();

    mem_load_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mem [256];
    exp_t        q [$];
    int          re_due = -1;
    logic [7:0]  m_addr = '0;
    int          free_at = 0;
    logic        acc_flag = 1'b0;
    int          acc_n = 0;
    int          got_cyc = -1;
    logic [31:0] got_data;
    logic [4:0]  got_rd;
    logic        got_err;

    logic [5:0]  d_op   [12] = '{6'h20, 6'h20, 6'h24, 6'h20, 6'h24, 6'h21,
                                 6'h25, 6'h21, 6'h23, 6'h23, 6'h21, 6'h2B};
    logic [31:0] d_addr [12] = '{32'h11, 32'h12, 32'h12, 32'h13, 32'h10, 32'h12,
                                 32'h12, 32'h10, 32'h10, 32'h12, 32'h11, 32'h10};
    logic [31:0] d_exp  [12] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF,
                                 32'hFFFFFF80, 32'h00000001, 32'hFFFF80FF,
                                 32'h000080FF, 32'h00007F01, 32'h80FF7F01,
                                 32'h0, 32'h0, 32'h0};
    logic        d_err  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        else bus.mem_rdata <= $urandom;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Spec-level load semantics: {err, data}
    function automatic logic [32:0] model_load(logic [5:0] op, logic [31:0] addr,
                                               logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (addr % 4))) & 32'hFF;
        h = (addr % 4 >= 2) ? (w >> 16) : (w & 32'hFFFF);
        case (op)
            6'h20: return {1'b0, (b >= 128) ? b - 32'd256 : b};
            6'h24: return {1'b0, b};
            6'h21: begin
                if (addr % 2 != 0) return {1'b1, 32'h0};
                return {1'b0, (h >= 32768) ? h - 32'd65536 : h};
            end
            6'h25: begin
                if (addr % 2 != 0) return {1'b1, 32'h0};
                return {1'b0, h};
            end
            6'h23: begin
                if (addr % 4 != 0) return {1'b1, 32'h0};
                return {1'b0, w};
            end
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    always @(negedge clk) begin
        logic        ready_m;
        logic [32:0] r;
        acc_flag = 1'b0;
        if (rst) begin
            q.delete();
            re_due  = -1;
            m_addr  = '0;
            free_at = 0;
            chk("rst_ready", bus.req_ready, 1);
            chk("rst_stall", bus.stall, 0);
            chk("rst_mem_re", bus.mem_re, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_ld_valid", bus.ld_valid, 0);
            chk("rst_ld_err", bus.ld_err, 0);
            chk("rst_ld_data", bus.ld_data, 0);
            chk("rst_ld_rd", bus.ld_rd, 0);
        end else begin
            ready_m = (cyc >= free_at);
            chk("req_ready", bus.req_ready, ready_m);
            chk("stall", bus.stall, !ready_m);
            chk("mem_re", bus.mem_re, cyc == re_due);
            chk("mem_addr", bus.mem_addr, m_addr);
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("ld_valid", bus.ld_valid, 1);
                chk("ld_data", bus.ld_data, q[0].data);
                chk("ld_rd", bus.ld_rd, q[0].rd);
                chk("ld_err", bus.ld_err, q[0].err);
                got_data = bus.ld_data;
                got_rd   = bus.ld_rd;
                got_err  = bus.ld_err;
                got_cyc  = cyc;
                void'(q.pop_front());
            end else begin
                chk("ld_valid_idle", bus.ld_valid, 0);
            end
            if (bus.req_valid && ready_m) begin
                acc_flag = 1'b1;
                acc_n    = cyc;
                r = model_load(bus.req_op, bus.req_addr, mem[bus.req_addr[9:2]]);
                if (r[32]) begin
                    q.push_back('{cyc + 1, 32'h0, bus.req_rd, 1'b1});
                end else begin
                    q.push_back('{cyc + 3, r[31:0], bus.req_rd, 1'b0});
                    re_due  = cyc + 1;
                    m_addr  = bus.req_addr[9:2];
                    free_at = cyc + 3;
                end
            end
        end
    end

    task automatic issue(logic [5:0] op, logic [31:0] addr, logic [4:0] rd);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_rd    = rd;
        do begin
            @(posedge clk);
            n++;
        end while (!acc_flag && n < 20);
        chk("accept_in_time", acc_flag, 1);
        #1;
    endtask

    task automatic idle(int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_result(int a);
        int n = 0;
        while (got_cyc <= a && n < 10) begin
            @(posedge clk);
            n++;
        end
        chk("result_in_time", got_cyc > a, 1);
        #1;
    endtask

    task automatic pulse_rst(int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [32:0] r;
        logic [5:0]  op;
        int          a;
        int          a2;
        int          g;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_rd    = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[4] = 32'h80FF7F01;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 12; i++) begin
            r = model_load(d_op[i], d_addr[i], mem[4]);
            chk("model_pin", r, {d_err[i], d_exp[i]});
            issue(d_op[i], d_addr[i], 5'(i + 3));
            a = acc_n;
            if (i == 0) begin
                chk("lb11_mem_re", bus.mem_re, 1);
                chk("lb11_mem_addr", bus.mem_addr, 8'd4);
            end
            bus.req_valid = 1'b0;
            wait_result(a);
            chk("dir_data", got_data, d_exp[i]);
            chk("dir_err", got_err, d_err[i]);
            chk("dir_rd", got_rd, 5'(i + 3));
            chk("dir_latency", got_cyc - a, d_err[i] ? 1 : 3);
            idle(1);
        end

        issue(6'h23, 32'h10, 5'd7);
        a = acc_n;
        issue(6'h24, 32'h13, 5'd9);
        a2 = acc_n;
        bus.req_valid = 1'b0;
        chk("b2b_spacing", a2 - a, 3);
        wait_result(a2);
        chk("b2b_rd", got_rd, 5'd9);
        chk("b2b_data", got_data, 32'h00000080);
        idle(2);

        issue(6'h23, 32'h10, 5'd11);
        bus.req_valid = 1'b0;
        g = got_cyc;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        chk("rst_no_result", got_cyc, g);
        issue(6'h25, 32'h212, 5'd12);
        a = acc_n;
        bus.req_valid = 1'b0;
        wait_result(a);
        chk("post_rst_data", got_data, {16'h0, mem[132][31:16]});
        chk("post_rst_rd", got_rd, 5'd12);
        idle(1);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 6))
                0: op = 6'h20;
                1: op = 6'h21;
                2: op = 6'h23;
                3: op = 6'h24;
                4: op = 6'h25;
                5: op = 6'h23;
                default: op = 6'($urandom);
            endcase
            issue(op, $urandom, 5'($urandom));
            if ($urandom_range(0, 29) == 0) pulse_rst($urandom_range(0, 2));
            else idle($urandom_range(0, 2));
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
